// File: rtl/fx_ctrl_pkg.sv
// Shared control typedefs and default timing constants for the effects-pedal control path.
package fx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE             = 2'd0,
        PRESS_DEBOUNCE   = 2'd1,
        PRESSED          = 2'd2,
        RELEASE_DEBOUNCE = 2'd3
    } btn_state_t;

    // Defaults assume a 24 MHz system clock: 10 ms debounce, 2 s long press.
    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 32'd240000;
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 32'd48000000;

    // Counter width that can hold the value 'limit' itself without wrapping.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit) + 32'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs, resetting to a parameterized value.
module sync_2ff #(
    parameter int unsigned          WIDTH     = 32'd1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Raw footswitch/pushbutton -> debounced level plus single-cycle press and long-press pulses.
// Long-press detection is built only when FX_BTN_LONG_PRESS_EN is defined.
module button_conditioner
    import fx_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter bit          ACTIVE_LOW        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic long_press_pulse
);

    localparam int unsigned        DEB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0]   DEB_ZERO = DEB_W'(32'd0);
    localparam logic [DEB_W-1:0]   DEB_ONE  = DEB_W'(32'd1);
    localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             btn_norm_s;
    logic             btn_s;
    btn_state_t       state_r;
    btn_state_t       state_nxt_s;
    logic [DEB_W-1:0] deb_cnt_r;
    logic [DEB_W-1:0] deb_nxt_s;
    logic             press_nxt_s;
    logic             level_nxt_s;

    // Normalize polarity so everything downstream treats 1 as pressed.
    assign btn_norm_s = ACTIVE_LOW ? ~btn_raw : btn_raw;

    sync_2ff #(
        .WIDTH     (32'd1),
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_norm_s),
        .q   (btn_s)
    );

    // Debounce state machine next-state and press-pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        deb_nxt_s   = deb_cnt_r;
        press_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_s) begin
                    state_nxt_s = PRESS_DEBOUNCE;
                    deb_nxt_s   = DEB_ZERO;
                end else begin
                    deb_nxt_s   = DEB_ZERO;
                end
            end
            PRESS_DEBOUNCE: begin
                if (!btn_s) begin
                    state_nxt_s = IDLE;
                    deb_nxt_s   = DEB_ZERO;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s = PRESSED;
                    deb_nxt_s   = DEB_ZERO;
                    press_nxt_s = 1'b1;
                end else begin
                    deb_nxt_s   = deb_cnt_r + DEB_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt_s = RELEASE_DEBOUNCE;
                    deb_nxt_s   = DEB_ZERO;
                end else begin
                    deb_nxt_s   = DEB_ZERO;
                end
            end
            RELEASE_DEBOUNCE: begin
                // A bounce back to pressed resumes the same press without a new pulse.
                if (btn_s) begin
                    state_nxt_s = PRESSED;
                    deb_nxt_s   = DEB_ZERO;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s = IDLE;
                    deb_nxt_s   = DEB_ZERO;
                end else begin
                    deb_nxt_s   = deb_cnt_r + DEB_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                deb_nxt_s   = DEB_ZERO;
            end
        endcase
        level_nxt_s = (state_nxt_s == PRESSED) || (state_nxt_s == RELEASE_DEBOUNCE);
    end

    // State, debounce counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            deb_cnt_r   <= DEB_ZERO;
            btn_level   <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            deb_cnt_r   <= deb_nxt_s;
            btn_level   <= level_nxt_s;
            press_pulse <= press_nxt_s;
        end
    end

`ifdef FX_BTN_LONG_PRESS_EN
    localparam int unsigned        HOLD_W    = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_ZERO = HOLD_W'(32'd0);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(32'd1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 32'd1);

    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_nxt_s;
    logic              long_nxt_s;

    // Hold counter: cleared on each accepted press, saturating so the pulse fires once.
    always_comb begin
        hold_nxt_s = hold_cnt_r;
        long_nxt_s = 1'b0;
        if (press_nxt_s) begin
            hold_nxt_s = HOLD_ZERO;
        end else if (((state_r == PRESSED) || (state_r == RELEASE_DEBOUNCE)) &&
                     (hold_cnt_r != HOLD_MAX)) begin
            hold_nxt_s = hold_cnt_r + HOLD_ONE;
            long_nxt_s = (hold_cnt_r == HOLD_LAST);
        end else begin
            hold_nxt_s = hold_cnt_r;
        end
    end

    // Hold counter and long-press output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r       <= HOLD_ZERO;
            long_press_pulse <= 1'b0;
        end else begin
            hold_cnt_r       <= hold_nxt_s;
            long_press_pulse <= long_nxt_s;
        end
    end
`else
    assign long_press_pulse = 1'b0;

    // Keeps the long-press threshold part of the interface; an illegal value shows up as this block.
    if (LONG_PRESS_CYCLES < 32'd2) begin : g_long_press_cfg_illegal
    end
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: active-high and active-low instances share one stimulus.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_raw_al;
    logic lvl, prs, lng;
    logic lvl_al, prs_al, lng_al;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int start;
        int hold;
        int total;
        int pe;
        int le;
        int re;
    } vec_t;

    vec_t vecs[8];

    assign btn_raw_al = ~btn_raw;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES   (32'd4),
        .LONG_PRESS_CYCLES (32'd20),
        .ACTIVE_LOW        (1'b0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_raw          (btn_raw),
        .btn_level        (lvl),
        .press_pulse      (prs),
        .long_press_pulse (lng)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES   (32'd4),
        .LONG_PRESS_CYCLES (32'd20),
        .ACTIVE_LOW        (1'b1)
    ) dut_al (
        .clk              (clk),
        .rst              (rst),
        .btn_raw          (btn_raw_al),
        .btn_level        (lvl_al),
        .press_pulse      (prs_al),
        .long_press_pulse (lng_al)
    );

    task automatic check(input string name, input int e, input logic act, input logic exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s edge %0d: got %b expected %b", name, e, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int e,
                             input logic el, input logic ep, input logic elg);
        check({name, ".level"},       e, lvl,    el);
        check({name, ".press"},       e, prs,    ep);
        check({name, ".long"},        e, lng,    elg);
        check({name, ".level_al"},    e, lvl_al, el);
        check({name, ".press_al"},    e, prs_al, ep);
        check({name, ".long_al"},     e, lng_al, elg);
    endtask

    function automatic logic exp_long(input int e, input int le);
`ifdef FX_BTN_LONG_PRESS_EN
        return (le != 0) && (e == le);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] span(input int start, input int hold);
        logic [63:0] p;
        p = 64'd0;
        for (int i = start; i < start + hold; i++) p[i] = 1'b1;
        return p;
    endfunction

    // pat[e] is the raw level sampled at edge e; pe/le = pulse edges (0 = none), level high on [pe, re).
    task automatic run(input string name, input logic [63:0] pat, input int total,
                       input int pe, input int le, input int re);
        for (int e = 1; e <= total; e++) begin
            btn_raw = pat[e];
            @(posedge clk);
            #1;
            check_all(name, e, (pe != 0) && (e >= pe) && (e < re), (e == pe), exp_long(e, le));
        end
    endtask

    initial begin
        vecs[0] = '{10, 40, 60, 16, 36, 56};
        vecs[1] = '{10, 40, 60, 16, 36, 56};
        vecs[2] = '{3,  10, 25,  9,  0, 19};
        vecs[3] = '{2,   1, 12,  0,  0,  0};
        vecs[4] = '{1,   4, 20,  0,  0,  0};
        vecs[5] = '{1,   5, 25,  7,  0, 12};
        vecs[6] = '{1,  20, 40,  7, 27, 27};
        vecs[7] = '{1,  19, 40,  7,  0, 26};

        rst     = 1'b1;
        btn_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        run("idle", 64'd0, 5, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run($sformatf("vec%0d", i), span(vecs[i].start, vecs[i].hold), vecs[i].total,
                vecs[i].pe, vecs[i].le, vecs[i].re);
        end

        // Short burst then a dip restarts debounce; only the settled press pulses.
        run("bounce", span(1, 3) | span(5, 16), 35, 11, 0, 27);

        // Two-cycle release glitch returns to PRESSED; hold count keeps running.
        run("glitch", span(1, 14) | span(17, 8), 40, 7, 27, 31);

        // Reset while pressed, button held across deassertion counts as a fresh press.
        run("pre_rst", span(1, 10), 10, 7, 0, 63);
        #1;
        rst = 1'b1;
        #1;
        check_all("rst_async", 0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk);
            #1;
            check_all("rst_hold", i, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        run("post_rst", span(1, 15), 30, 7, 0, 22);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
